isoiec7816_tx_arq: RTL

Parametrised ISO/IEC 7816-3 character transmitter with T=0 error-signal detection and automatic character repetition. It serialises one byte per valid/ready handshake onto the I/O line in direct or inverse convention, then releases the line. In T=0 mode it samples the receiver's error signal during the guard time and repeats the character up to `MAX_RETRIES` times. It sits between the protocol controller and the open-drain I/O pad, beside the existing receiver.

---
 rtl/isoiec7816_tx_arq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/isoiec7816_tx_arq.sv
// ISO/IEC 7816-3 character transmitter for direct or inverse convention.
// In T=0 it samples the receiver's error signal and repeats the character; T=1 uses a short guard time.
module isoiec7816_tx_arq #(
    parameter int ETU_WIDTH   = 11,
    parameter int EGT_WIDTH   = 8,
    parameter int MAX_RETRIES = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_in,
    output logic                 serial,
    output logic                 oe,
    input  logic                 inverse,
    input  logic                 t1,
    input  logic [ETU_WIDTH-1:0] etu,
    input  logic [EGT_WIDTH-1:0] egt,
    input  logic [7:0]           char,
    input  logic                 valid,
    output logic                 ready,
    output logic                 transmitted,
    output logic                 failed,
    output logic [3:0]           retry_count
);

    localparam int GW = EGT_WIDTH + 2;
    localparam logic [3:0]           RETRY_MAX = 4'(MAX_RETRIES);
    localparam logic [ETU_WIDTH-1:0] CNT_ZERO  = {ETU_WIDTH{1'b0}};
    localparam logic [ETU_WIDTH-1:0] CNT_ONE   = ETU_WIDTH'(1'b1);
    localparam logic [GW-1:0]        GRD_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0]        GRD_ONE   = GW'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GUARD = 2'd2
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // Bit i of the result is the line level of frame bit i; bit 0 is always the start bit.
    function automatic logic [9:0] build_frame(input logic [7:0] d, input logic inv);
        logic [9:0] f;
        f = 10'd0;
        if (inv) begin
            for (int i = 0; i < 8; i++) begin
                f[i+1] = ~d[7-i];
            end
            f[9] = ~even_parity(d);
        end else begin
            f[8:1] = d;
            f[9]   = even_parity(d);
        end
        return f;
    endfunction

    function automatic logic [GW-1:0] guard_last(input logic t1m, input logic err,
                                                 input logic [EGT_WIDTH-1:0] g);
        logic [GW-1:0] base;
        base = GW'(g);
        if (t1m) begin
            return base;
        end else if (err) begin
            return base + GW'(2'd2);
        end else begin
            return base + GW'(2'd1);
        end
    endfunction

    state_t               state_r;
    logic [1:0]           sync_r;
    logic [9:0]           frame_r;
    logic                 t1_r;
    logic [ETU_WIDTH-1:0] etu_r;
    logic [EGT_WIDTH-1:0] egt_r;
    logic [3:0]           bit_idx_r;
    logic [ETU_WIDTH-1:0] bit_cnt_r;
    logic [GW-1:0]        guard_cnt_r;
    logic                 err_r;
    logic [3:0]           retry_r;
    logic                 serial_r;
    logic                 oe_r;
    logic                 ready_r;
    logic                 transmitted_r;
    logic                 failed_r;

    state_t               nxt_state_s;
    logic [3:0]           nxt_idx_s;
    logic [ETU_WIDTH-1:0] nxt_cnt_s;
    logic [GW-1:0]        nxt_guard_s;
    logic                 accept_s;
    logic                 restart_s;
    logic                 sample_s;
    logic                 err_now_s;
    logic                 err_nxt_s;
    logic [GW-1:0]        glast_s;
    logic                 last_nxt_s;
    logic                 retry_ok_s;

    // Error sample point: clock floor((etu+1)/2) of guard etu 0, i.e. down-counter value floor(etu/2).
    assign sample_s   = (state_r == GUARD) && !t1_r && (guard_cnt_r == GRD_ZERO)
                        && (bit_cnt_r == (etu_r >> 1));
    assign err_now_s  = sample_s ? ~sync_r[1] : err_r;
    assign err_nxt_s  = (state_r == GUARD) ? err_now_s : 1'b0;
    assign glast_s    = guard_last(t1_r, err_now_s, egt_r);
    assign retry_ok_s = (retry_r < RETRY_MAX);
    // Pulses are registered, so they are raised on the edge that enters the final guard clock.
    assign last_nxt_s = (nxt_state_s == GUARD) && (nxt_cnt_s == CNT_ZERO)
                        && (nxt_guard_s == guard_last(t1_r, err_nxt_s, egt_r));

    // Next-state and counter evaluation for the frame/guard sequencer.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = bit_idx_r;
        nxt_cnt_s   = bit_cnt_r;
        nxt_guard_s = guard_cnt_r;
        accept_s    = 1'b0;
        restart_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid && ready_r) begin
                    accept_s    = 1'b1;
                    nxt_state_s = FRAME;
                    nxt_idx_s   = 4'd0;
                    nxt_cnt_s   = etu;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            FRAME: begin
                if (bit_cnt_r != CNT_ZERO) begin
                    nxt_cnt_s = bit_cnt_r - CNT_ONE;
                end else if (bit_idx_r == 4'd9) begin
                    nxt_state_s = GUARD;
                    nxt_cnt_s   = etu_r;
                    nxt_guard_s = GRD_ZERO;
                end else begin
                    nxt_idx_s = bit_idx_r + 4'd1;
                    nxt_cnt_s = etu_r;
                end
            end
            GUARD: begin
                if (bit_cnt_r != CNT_ZERO) begin
                    nxt_cnt_s = bit_cnt_r - CNT_ONE;
                end else if (guard_cnt_r != glast_s) begin
                    nxt_guard_s = guard_cnt_r + GRD_ONE;
                    nxt_cnt_s   = etu_r;
                end else if (err_now_s && retry_ok_s) begin
                    restart_s   = 1'b1;
                    nxt_state_s = FRAME;
                    nxt_idx_s   = 4'd0;
                    nxt_cnt_s   = etu_r;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Sequencer state, latched character settings and registered line/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            sync_r        <= 2'b11;
            frame_r       <= 10'd0;
            t1_r          <= 1'b0;
            etu_r         <= CNT_ZERO;
            egt_r         <= {EGT_WIDTH{1'b0}};
            bit_idx_r     <= 4'd0;
            bit_cnt_r     <= CNT_ZERO;
            guard_cnt_r   <= GRD_ZERO;
            err_r         <= 1'b0;
            retry_r       <= 4'd0;
            serial_r      <= 1'b1;
            oe_r          <= 1'b0;
            ready_r       <= 1'b0;
            transmitted_r <= 1'b0;
            failed_r      <= 1'b0;
        end else begin
            sync_r        <= {sync_r[0], io_in};
            state_r       <= nxt_state_s;
            bit_idx_r     <= nxt_idx_s;
            bit_cnt_r     <= nxt_cnt_s;
            guard_cnt_r   <= nxt_guard_s;
            err_r         <= err_nxt_s;
            ready_r       <= (nxt_state_s == IDLE);
            transmitted_r <= last_nxt_s && !err_nxt_s;
            failed_r      <= last_nxt_s && err_nxt_s && !retry_ok_s;
            // frame_r[0] is the start bit of every frame, so the stale frame is safe on the accept edge.
            if (nxt_state_s == FRAME) begin
                oe_r     <= 1'b1;
                serial_r <= frame_r[nxt_idx_s];
            end else begin
                oe_r     <= 1'b0;
                serial_r <= 1'b1;
            end
            if (accept_s) begin
                frame_r <= build_frame(char, inverse);
                t1_r    <= t1;
                etu_r   <= etu;
                egt_r   <= egt;
                retry_r <= 4'd0;
            end else if (restart_s) begin
                retry_r <= retry_r + 4'd1;
            end
        end
    end

    assign serial      = serial_r;
    assign oe          = oe_r;
    assign ready       = ready_r;
    assign transmitted = transmitted_r;
    assign failed      = failed_r;
    assign retry_count = retry_r;

endmodule
